knn_vote: RTL and testbench

- Downstream consumer of the KNN core's sorted neighbour-label vector.
- Latches the N_NEIGHBOUR labels on a start pulse, builds a per-class vote histogram and scans it.
- Reports the majority class. Ties go to the class owning the nearest neighbour.
- Sits between the KNN core's Neighbour_info output and the software-visible result registers.

---
 rtl/knn_vote_pkg.sv | 21 ++
 rtl/knn_vote_hist.sv | 44 ++++
 rtl/knn_vote.sv | 153 +++++++++++++++
 tb/tb_knn_vote.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/knn_vote_pkg.sv
// Shared constants, FSM encoding and width helper for the KNN majority-vote block.
package knn_vote_pkg;

  localparam int unsigned DEF_LABEL       = 8;
  localparam int unsigned DEF_N_NEIGHBOUR = 10;
  localparam int unsigned DEF_N_CLASSES   = 10;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StCount,
    StScan,
    StDone
  } vote_state_e;

  // Minimum width of 1 so single-value ranges still give a legal vector.
  function automatic int unsigned clog2_u(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/knn_vote_hist.sv
// Per-class vote counters and first-occurrence slot indices.
module knn_vote_hist
  import knn_vote_pkg::*;
#(
  parameter int unsigned N_NEIGHBOUR = DEF_N_NEIGHBOUR,
  parameter int unsigned N_CLASSES   = DEF_N_CLASSES,
  parameter int unsigned CNT_W       = clog2_u(N_NEIGHBOUR + 1),
  parameter int unsigned CLS_W       = clog2_u(N_CLASSES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [CLS_W-1:0] inc_cls,
  input  logic [CNT_W-1:0] inc_pos,
  input  logic [CLS_W-1:0] rd_cls,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] rd_first
);

  localparam logic [CNT_W-1:0] NoSlot = CNT_W'(N_NEIGHBOUR);

  logic [CNT_W-1:0] cnt_q   [N_CLASSES];
  logic [CNT_W-1:0] first_q [N_CLASSES];

  // NoSlot in first_q marks a class that has not been seen yet.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      for (int c = 0; c < N_CLASSES; c++) begin
        cnt_q[c]   <= '0;
        first_q[c] <= NoSlot;
      end
    end else if (inc) begin
      cnt_q[inc_cls] <= cnt_q[inc_cls] + 1'b1;
      if (first_q[inc_cls] == NoSlot) begin
        first_q[inc_cls] <= inc_pos;
      end
    end
  end

  assign rd_cnt   = cnt_q[rd_cls];
  assign rd_first = first_q[rd_cls];

endmodule

// File: rtl/knn_vote.sv
// Majority vote over the K nearest-neighbour labels; ties go to the nearest neighbour's class.
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int unsigned LABEL       = DEF_LABEL,
  parameter int unsigned N_NEIGHBOUR = DEF_N_NEIGHBOUR,
  parameter int unsigned N_CLASSES   = DEF_N_CLASSES,
  parameter int unsigned CNT_W       = clog2_u(N_NEIGHBOUR + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CNT_W-1:0]             n_valid,
  input  logic [N_NEIGHBOUR*LABEL-1:0] info_in,
  output logic                         busy,
  output logic                         done,
  output logic [LABEL-1:0]             label_out,
  output logic [CNT_W-1:0]             votes_out,
  output logic                         label_valid
);

  localparam int unsigned      CLS_W   = clog2_u(N_CLASSES);
  localparam logic [CNT_W-1:0] NoSlot  = CNT_W'(N_NEIGHBOUR);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_NEIGHBOUR - 1);
  localparam logic [CLS_W-1:0] LastCls = CLS_W'(N_CLASSES - 1);

  vote_state_e state_q, state_d;
  logic capture, hist_clear, count_en, scan_en;

  logic [N_NEIGHBOUR*LABEL-1:0] labels_q;
  logic [CNT_W-1:0] nvalid_q, idx_q;
  logic [CLS_W-1:0] scan_q, best_q, best_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d, best_first_q, best_first_d;
  logic [LABEL-1:0] label_q;
  logic [CNT_W-1:0] votes_q;
  logic             valid_q;

  logic [LABEL-1:0] cur_lab;
  logic             inc, take;
  logic [CNT_W-1:0] rd_cnt, rd_first;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    hist_clear = 1'b0;
    count_en   = 1'b0;
    scan_en    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          capture = 1'b1;
          state_d = StClear;
        end
      end
      StClear: begin
        hist_clear = 1'b1;
        state_d    = StCount;
      end
      StCount: begin
        count_en = 1'b1;
        if (idx_q == LastIdx) state_d = StScan;
      end
      StScan: begin
        scan_en = 1'b1;
        if (scan_q == LastCls) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign cur_lab = labels_q[int'(idx_q) * LABEL +: LABEL];
  assign inc     = count_en && (idx_q < nvalid_q) && (32'(cur_lab) < N_CLASSES);

  knn_vote_hist #(
    .N_NEIGHBOUR(N_NEIGHBOUR),
    .N_CLASSES  (N_CLASSES),
    .CNT_W      (CNT_W),
    .CLS_W      (CLS_W)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clear   (hist_clear),
    .inc     (inc),
    .inc_cls (cur_lab[CLS_W-1:0]),
    .inc_pos (idx_q),
    .rd_cls  (scan_q),
    .rd_cnt  (rd_cnt),
    .rd_first(rd_first)
  );

  // Strictly-greater keeps the earlier class; equal counts fall back to the nearer first slot.
  always_comb begin
    take = (rd_cnt > best_cnt_q) ||
           ((rd_cnt == best_cnt_q) && (rd_cnt != '0) && (rd_first < best_first_q));
    best_d       = take ? scan_q   : best_q;
    best_cnt_d   = take ? rd_cnt   : best_cnt_q;
    best_first_d = take ? rd_first : best_first_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      labels_q     <= '0;
      nvalid_q     <= '0;
      idx_q        <= '0;
      scan_q       <= '0;
      best_q       <= '0;
      best_cnt_q   <= '0;
      best_first_q <= NoSlot;
      label_q      <= '0;
      votes_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      if (capture) begin
        labels_q <= info_in;
        nvalid_q <= (n_valid > NoSlot) ? NoSlot : n_valid;
      end
      if (hist_clear) begin
        idx_q        <= '0;
        scan_q       <= '0;
        best_q       <= '0;
        best_cnt_q   <= '0;
        best_first_q <= NoSlot;
      end else if (count_en) begin
        idx_q <= idx_q + 1'b1;
      end
      if (scan_en) begin
        scan_q       <= scan_q + 1'b1;
        best_q       <= best_d;
        best_cnt_q   <= best_cnt_d;
        best_first_q <= best_first_d;
        // Publish on the final scan edge so results are stable while done is high.
        if (scan_q == LastCls) begin
          label_q <= LABEL'(best_d);
          votes_q <= best_cnt_d;
          valid_q <= (best_cnt_d != '0);
        end
      end
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign label_out   = label_q;
  assign votes_out   = votes_q;
  assign label_valid = valid_q;

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: directed cases from the test plan plus randomized runs.
module tb_knn_vote;

  localparam int L = 8;
  localparam int N = 10;
  localparam int C = 10;
  localparam int W = 4;
  localparam int LATENCY = N + C + 1;  // edges from start edge to the edge entering DONE

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   n_valid = '0;
  logic [N*L-1:0] info_in = '0;
  logic           busy, done, label_valid;
  logic [L-1:0]   label_out;
  logic [W-1:0]   votes_out;

  knn_vote dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_valid    (n_valid),
    .info_in    (info_in),
    .busy       (busy),
    .done       (done),
    .label_out  (label_out),
    .votes_out  (votes_out),
    .label_valid(label_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int lab;
    int votes;
    int valid;
    int cyc;
  } exp_t;

  exp_t      sb[$];
  logic [7:0] lab[N];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: count valid labels per class, the winner is the class of the earliest
  // counted slot whose class holds the maximum count.
  function automatic exp_t model(input int nv);
    exp_t e;
    int   cnt[C];
    int   n, mx;
    e = '{lab: 0, votes: 0, valid: 0, cyc: 0};
    n = (nv > N) ? N : nv;
    for (int c = 0; c < C; c++) cnt[c] = 0;
    for (int i = 0; i < n; i++) if (lab[i] < C) cnt[lab[i]]++;
    mx = 0;
    for (int c = 0; c < C; c++) if (cnt[c] > mx) mx = cnt[c];
    if (mx > 0) begin
      for (int i = 0; i < n; i++) begin
        if (lab[i] < C && cnt[lab[i]] == mx) begin
          e.lab   = lab[i];
          e.votes = mx;
          e.valid = 1;
          break;
        end
      end
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever done is presented.
  exp_t got;
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done high with no outstanding request (cycle %0d)", cyc);
      end else begin
        got = sb.pop_front();
        chk("label_out", int'(label_out), got.lab);
        chk("votes_out", int'(votes_out), got.votes);
        chk("label_valid", int'(label_valid), got.valid);
        chk("done_cycle", cyc, got.cyc);
      end
    end
  end

  task automatic pack_labels();
    for (int i = 0; i < N; i++) info_in[i*L +: L] = lab[i];
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input int nv);
    exp_t e;
    pack_labels();
    n_valid = W'(nv);
    start   = 1'b1;
    e       = model(nv);
    e.cyc   = cyc + 1 + LATENCY;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_n);
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      busy_n += int'(busy);
      if (done) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: no done within 40 cycles, expected one (cycle %0d)", cyc);
  endtask

  task automatic run(input int nv);
    int   bn;
    exp_t e;
    e = model(nv);
    issue(nv);
    wait_done(bn);
    chk("busy_cycles", bn, LATENCY + 1);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("label_held", int'(label_out), e.lab);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_label"}, int'(label_out), 0);
    chk({tag, "_votes"}, int'(votes_out), 0);
    chk({tag, "_valid"}, int'(label_valid), 0);
  endtask

  initial begin
    int bn;
    for (int i = 0; i < N; i++) lab[i] = 8'd0;

    // Reset held for three cycles with start asserted.
    rst   = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs("reset");
    end
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Clear majority.
    lab = '{8'd3, 8'd3, 8'd5, 8'd3, 8'd1, 8'd3, 8'd5, 8'd7, 8'd3, 8'd2};
    run(10);

    // Tie-break by nearest neighbour.
    lab = '{8'd4, 8'd2, 8'd2, 8'd4, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    run(4);

    // Invalid labels filtered; n_valid limits the window.
    lab = '{8'd12, 8'd12, 8'd12, 8'd6, 8'd0, 8'd6, 8'd6, 8'd6, 8'd6, 8'd6};
    run(5);
    run(0);
    lab = '{8'd200, 8'd10, 8'd11, 8'd255, 8'd13, 8'd10, 8'd99, 8'd12, 8'd14, 8'd15};
    run(10);

    // n_valid above N is clamped.
    lab = '{8'd1, 8'd8, 8'd8, 8'd1, 8'd9, 8'd9, 8'd9, 8'd0, 8'd0, 8'd0};
    run(15);

    // Start while busy is ignored and the snapshot is isolated from later input changes.
    lab = '{8'd7, 8'd7, 8'd2, 8'd2, 8'd2, 8'd7, 8'd7, 8'd1, 8'd1, 8'd0};
    issue(10);
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) lab[i] = 8'd5;
    pack_labels();
    n_valid = W'(3);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bn);
    chk("busy_start_busy_cycles", bn, LATENCY + 1 - 5);
    repeat (30) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    run(3);

    // Reset during SCAN.
    lab = '{8'd6, 8'd6, 8'd6, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd8};
    issue(10);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst = 1'b1;
    repeat (30) @(negedge clk);
    run(10);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) lab[i] = 8'($urandom_range(0, 13));
      run($urandom_range(0, 15));
    end

    repeat (3) @(negedge clk);
    chk("final_scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
